// File: rtl/bs_pkg.sv
// ============================================================
// bs_pkg : shared FSM state encoding and board-size default
// Rev 1.0
// ============================================================
`default_nettype none

package bs_pkg;

    localparam int N_CELLS_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        SCORE  = 2'd2,
        REPORT = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bs_popcount.sv
// ============================================================
// bs_popcount : combinational count of set bits
// Rev 1.0
// ============================================================
`default_nettype none

module bs_popcount
    import bs_pkg::*;
#(
    parameter int N_CELLS = N_CELLS_DEFAULT,
    parameter int CW      = $clog2(N_CELLS + 1)
) (
    input  logic [N_CELLS-1:0] bits,
    output logic [CW-1:0]      count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/attack_checker.sv
// ============================================================
// attack_checker : validates and scores cumulative board attacks
// Rev 1.0
// ============================================================
`default_nettype none

module attack_checker
    import bs_pkg::*;
#(
    parameter int N_CELLS = N_CELLS_DEFAULT,
    parameter int LW      = $clog2(N_CELLS + 1)
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               load,
    input  logic [N_CELLS-1:0] ship_map,
    input  logic               start,
    input  logic [N_CELLS-1:0] attack,
    output logic               busy,
    output logic               done,
    output logic               ok,
    output logic               hit,
    output logic [LW-1:0]      lives,
    output logic               alive,
    output logic [N_CELLS-1:0] shots
);

    state_t             r_state;
    state_t             w_state_next;
    logic [N_CELLS-1:0] r_ships;
    logic [N_CELLS-1:0] r_shots;
    logic [N_CELLS-1:0] r_cap;
    logic [LW-1:0]      r_lives;
    logic               r_valid;
    logic               r_hit;

    logic [N_CELLS-1:0] w_new;
    logic [N_CELLS-1:0] w_cleared;
    logic [LW-1:0]      w_map_count;
    logic [LW-1:0]      w_new_count;
    logic               w_strike;

    assign w_new     = r_cap & ~r_shots;
    assign w_cleared = r_shots & ~r_cap;
    assign w_strike  = |(w_new & r_ships);

    bs_popcount #(.N_CELLS(N_CELLS), .CW(LW)) u_pop_map (
        .bits  (ship_map),
        .count (w_map_count)
    );

    bs_popcount #(.N_CELLS(N_CELLS), .CW(LW)) u_pop_new (
        .bits  (w_new),
        .count (w_new_count)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // load wins over start in IDLE, so a simultaneous start is dropped
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start && !load) w_state_next = CHECK;
            CHECK:   w_state_next = SCORE;
            SCORE:   w_state_next = REPORT;
            REPORT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_ships <= '0;
            r_shots <= '0;
            r_cap   <= '0;
            r_lives <= '0;
            r_valid <= 1'b0;
            r_hit   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_ships <= ship_map;
                        r_shots <= '0;
                        r_lives <= w_map_count;
                    end else if (start) begin
                        r_cap <= attack;
                    end
                end
                CHECK: begin
                    r_valid <= (w_cleared == '0) && (w_new_count == LW'(1)) && alive;
                end
                SCORE: begin
                    if (r_valid) begin
                        r_shots <= r_cap;
                        r_hit   <= w_strike;
                        r_ships <= r_ships & ~w_new;
                        if (w_strike && (r_lives != '0)) begin
                            r_lives <= r_lives - LW'(1);
                        end
                    end else begin
                        r_hit <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != IDLE);
    assign done  = (r_state == REPORT);
    assign ok    = done && r_valid;
    assign hit   = done && r_valid && r_hit;
    assign lives = r_lives;
    assign alive = (r_lives != '0);
    assign shots = r_shots;

endmodule

`default_nettype wire

// File: tb/tb_attack_checker.sv
// ============================================================
// tb_attack_checker : directed self-checking bench for attack_checker
// Rev 1.0
// ============================================================
`default_nettype none

module tb_attack_checker;

    localparam int N  = 16;
    localparam int LW = $clog2(N + 1);

    logic          clk;
    logic          clr_n;
    logic          load;
    logic [N-1:0]  ship_map;
    logic          start;
    logic [N-1:0]  attack;
    logic          busy;
    logic          done;
    logic          ok;
    logic          hit;
    logic [LW-1:0] lives;
    logic          alive;
    logic [N-1:0]  shots;

    int tests;
    int failed;

    attack_checker #(.N_CELLS(N), .LW(LW)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .load     (load),
        .ship_map (ship_map),
        .start    (start),
        .attack   (attack),
        .busy     (busy),
        .done     (done),
        .ok       (ok),
        .hit      (hit),
        .lives    (lives),
        .alive    (alive),
        .shots    (shots)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [N-1:0] map, input logic [LW-1:0] e_lives);
        load     = 1'b1;
        ship_map = map;
        @(posedge clk); #1;
        load = 1'b0;
        check("load_lives", 32'(lives), 32'(e_lives));
        check("load_alive", 32'(alive), 32'(e_lives != 0));
        check("load_shots", 32'(shots), 32'h0);
    endtask

    task automatic run_attack(input string tag, input logic [N-1:0] a, input logic e_ok,
                              input logic e_hit, input logic [LW-1:0] e_lives,
                              input logic [N-1:0] e_shots);
        int n;
        attack = a;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        check({tag, "_busy"}, 32'(busy), 32'h1);
        while (!done && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd3);
        check({tag, "_ok"}, 32'(ok), 32'(e_ok));
        check({tag, "_hit"}, 32'(hit), 32'(e_hit));
        check({tag, "_lives"}, 32'(lives), 32'(e_lives));
        check({tag, "_shots"}, 32'(shots), 32'(e_shots));
        @(posedge clk); #1;
        check({tag, "_done_off"}, {29'h0, done, ok, hit}, 32'h0);
        check({tag, "_idle"}, 32'(busy), 32'h0);
    endtask

    initial begin
        tests    = 0;
        failed   = 0;
        clr_n    = 1'b0;
        load     = 1'b0;
        start    = 1'b0;
        ship_map = '0;
        attack   = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", {26'h0, busy, done, ok, hit, alive, 1'b0}, 32'h0);
        check("rst_lives", 32'(lives), 32'h0);
        check("rst_shots", 32'(shots), 32'h0);
        clr_n = 1'b1;

        // no load yet: lives stay 0, so nothing can be accepted
        run_attack("noload", 16'h0001, 1'b0, 1'b0, 5'd0, 16'h0000);

        do_load(16'h000F, 5'd4);
        run_attack("a0001", 16'h0001, 1'b1, 1'b1, 5'd3, 16'h0001);
        run_attack("a0011", 16'h0011, 1'b1, 1'b0, 5'd3, 16'h0011);
        run_attack("a0030", 16'h0030, 1'b0, 1'b0, 5'd3, 16'h0011);
        run_attack("a0071", 16'h0071, 1'b0, 1'b0, 5'd3, 16'h0011);
        run_attack("same",  16'h0011, 1'b0, 1'b0, 5'd3, 16'h0011);
        run_attack("a0013", 16'h0013, 1'b1, 1'b1, 5'd2, 16'h0013);
        run_attack("a0017", 16'h0017, 1'b1, 1'b1, 5'd1, 16'h0017);
        run_attack("a001F", 16'h001F, 1'b1, 1'b1, 5'd0, 16'h001F);
        check("dead_alive", 32'(alive), 32'h0);
        run_attack("dead", 16'h003F, 1'b0, 1'b0, 5'd0, 16'h001F);

        // every cell shot: single ship in the top cell, sunk last
        do_load(16'h8000, 5'd1);
        for (int i = 1; i < N; i++) begin
            run_attack("fill", 16'((32'h1 << i) - 1), 1'b1, 1'b0, 5'd1, 16'((32'h1 << i) - 1));
        end
        run_attack("last", 16'hFFFF, 1'b1, 1'b1, 5'd0, 16'hFFFF);
        run_attack("full", 16'hFFFF, 1'b0, 1'b0, 5'd0, 16'hFFFF);

        // load and start together: load taken, start dropped
        load     = 1'b1;
        start    = 1'b1;
        ship_map = 16'h00F0;
        attack   = 16'h0010;
        @(posedge clk); #1;
        load  = 1'b0;
        start = 1'b0;
        check("ls_lives", 32'(lives), 32'd4);
        check("ls_shots", 32'(shots), 32'h0);
        check("ls_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("ls_no_done", 32'(done), 32'h0);
        end

        // reset asserted while in SCORE
        attack = 16'h0010;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        clr_n = 1'b0;
        #1;
        check("mid_outs", {27'h0, busy, done, ok, hit, alive}, 32'h0);
        check("mid_lives", 32'(lives), 32'h0);
        check("mid_shots", 32'(shots), 32'h0);
        #2;
        clr_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("mid_no_done", 32'(done), 32'h0);
        end
        check("mid_lives_after", 32'(lives), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/attack_checker.md
ATTACK_CHECKER -- requirements
Module: attack_checker

Interface
REQ-001 SHALL have parameter N_CELLS, default 16, meaning the number of board cells (one bit per cell).
REQ-002 SHALL have parameter LW, default $clog2(N_CELLS+1), meaning the width of the lives counter.
REQ-003 SHALL have port clk  input  1  system clock, all state rising-edge.
REQ-004 SHALL have port clr_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port load  input  1  latch ship_map and start a new board (ship-placement phase).
REQ-006 SHALL have port ship_map  input  N_CELLS  ship positions, 1 = ship.
REQ-007 SHALL have port start  input  1  request validation/scoring of attack.
REQ-008 SHALL have port attack  input  N_CELLS  opponent's cumulative attack switches.
REQ-009 SHALL have port busy  output  1  high from start acceptance until done.
REQ-010 SHALL have port done  output  1  one-cycle result strobe.
REQ-011 SHALL have port ok  output  1  valid-attack flag, meaningful only with done.
REQ-012 SHALL have port hit  output  1  attack struck a ship, meaningful only with done.
REQ-013 SHALL have port lives  output  LW  ship cells remaining.
REQ-014 SHALL have port alive  output  1  lives != 0.
REQ-015 SHALL have port shots  output  N_CELLS  accepted cumulative attacks.

Function
REQ-016 SHALL implement FSM states IDLE, CHECK, SCORE, REPORT; IDLE->CHECK on accepted start, CHECK->SCORE, SCORE->REPORT, REPORT->IDLE unconditionally.
REQ-017 SHALL accept load and start only in IDLE; both are ignored while busy.
REQ-018 SHALL, on load in IDLE, set ships=ship_map, shots=0, lives=popcount(ship_map) on the next edge.
REQ-019 SHALL give load priority over start when both are high in IDLE; that start is dropped.
REQ-020 SHALL, on accepted start, register attack into an internal capture register on that edge.
REQ-021 SHALL, in CHECK, compute new=cap&~shots and cleared=shots&~cap and register valid=(cleared==0)&&(popcount(new)==1)&&alive.
REQ-022 SHALL, in SCORE with valid, set shots=cap, hit_r=|(new&ships), clear that bit in ships, and decrement lives by 1 on hit.
REQ-023 SHALL leave shots, ships, and lives unchanged in SCORE when not valid.
REQ-024 SHALL assert done for exactly the REPORT cycle, with ok=valid and hit=hit_r (hit=0 whenever ok=0).
REQ-025 SHALL give a latency of start-accept edge to done-high of 3 cycles, and accept the next start no earlier than the cycle after done.
REQ-026 SHALL never decrement lives below 0; alive SHALL be combinational from lives.
REQ-027 SHALL report ok=0 when zero new bits, more than one new bit, any previously accepted bit cleared, or alive=0.
REQ-028 SHALL, with an all-ones shots, reject every attack (ok=0).
REQ-029 SHALL hold ok/hit at 0 outside done.

Reset
REQ-030 SHALL, while clr_n=0, force state=IDLE, busy=0, done=0, ok=0, hit=0, lives=0, shots=0, ships=0, and capture=0 asynchronously.
REQ-031 SHALL abort any in-flight attack if reset is asserted mid-operation; no done is issued.
REQ-032 SHALL make a load required after reset release before lives becomes nonzero.

Structure
REQ-033 SHALL place the state enum and default N_CELLS in shared package bs_pkg.
REQ-034 SHALL use one sub-module, bs_popcount (parameterised N_CELLS, combinational), shared by load lives-count and CHECK one-hot test via two instances.

Verification
REQ-035 SHALL verify: load ship_map=16'h000F -> lives=4, alive=1, shots=0 next cycle.
REQ-036 SHALL verify: after REQ-035, start with attack=16'h0001 -> done 3 cycles later, ok=1, hit=1, lives=3, shots=16'h0001.
REQ-037 SHALL verify: then attack=16'h0011 -> ok=1, hit=0, lives=3; then attack=16'h0031 re-sent as 16'h0030 -> ok=0 (cleared bit), shots unchanged.
REQ-038 SHALL verify: attack=16'h0071 (two new bits) and attack equal to shots (no new bits) -> ok=0 each; hit=0.
REQ-039 SHALL verify: hit all four ship cells -> lives=0, alive=0; further valid-looking attack -> ok=0; load and start together in IDLE -> load taken, no done.
REQ-040 SHALL verify: clr_n low during SCORE -> all outputs 0 immediately, no done after release.
